// File: rtl/fighter_anim_pkg.sv
// Shared types and constants for the fighter animation sequencer and its
// sprite address pipeline.
package fighter_anim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WALK    = 2'd1,
        PUNCH   = 2'd2,
        HITSTUN = 2'd3
    } anim_t;

    // Frames per sheet (F) and frame_ticks per frame (T)
    localparam int IDLE_F    = 4;
    localparam int IDLE_T    = 8;
    localparam int WALK_F    = 4;
    localparam int WALK_T    = 6;
    localparam int PUNCH_F   = 3;
    localparam int PUNCH_T   = 4;
    localparam int HITSTUN_F = 2;
    localparam int HITSTUN_T = 6;

    localparam int DEF_BOX_W = 80;
    localparam int DEF_BOX_H = 160;
    localparam int DEF_SPR_W = 60;
    localparam int DEF_SPR_H = 90;

    function automatic logic [1:0] last_frame_of(anim_t a);
        case (a)
            IDLE:    last_frame_of = 2'(IDLE_F - 1);
            WALK:    last_frame_of = 2'(WALK_F - 1);
            PUNCH:   last_frame_of = 2'(PUNCH_F - 1);
            default: last_frame_of = 2'(HITSTUN_F - 1);
        endcase
    endfunction

    function automatic logic [2:0] last_tick_of(anim_t a);
        case (a)
            IDLE:    last_tick_of = 3'(IDLE_T - 1);
            WALK:    last_tick_of = 3'(WALK_T - 1);
            PUNCH:   last_tick_of = 3'(PUNCH_T - 1);
            default: last_tick_of = 3'(HITSTUN_T - 1);
        endcase
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Two-stage pipeline: hitbox-relative offset and in-box test, then scaling
// into sprite ROM coordinates with optional horizontal mirroring.
module sprite_addr_gen
    import fighter_anim_pkg::*;
#(
    parameter int BOX_W = DEF_BOX_W,
    parameter int BOX_H = DEF_BOX_H,
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        mirror,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic        in_box,
    output logic [12:0] rom_address
);

    logic [10:0] lx;
    logic [10:0] ly;
    logic        in_box_s1_next;

    logic [9:0]  lx_reg;
    logic [9:0]  ly_reg;
    logic        in_box_s1_reg;

    logic [19:0] sx_full;
    logic [19:0] sy_full;
    logic [19:0] col;
    logic [12:0] addr_full;
    logic [12:0] rom_address_next;

    // Bit 10 is the sign: pixels left of / above the box never alias inside it
    assign lx = {1'b0, draw_x} - {1'b0, pos_x};
    assign ly = {1'b0, draw_y} - {1'b0, pos_y};
    assign in_box_s1_next = !lx[10] && (lx < 11'(BOX_W)) &&
                            !ly[10] && (ly < 11'(BOX_H));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            lx_reg        <= '0;
            ly_reg        <= '0;
            in_box_s1_reg <= 1'b0;
        end else begin
            lx_reg        <= lx[9:0];
            ly_reg        <= ly[9:0];
            in_box_s1_reg <= in_box_s1_next;
        end
    end

    always_comb begin
        sx_full   = (20'(lx_reg) * 20'(SPR_W)) / 20'(BOX_W);
        sy_full   = (20'(ly_reg) * 20'(SPR_H)) / 20'(BOX_H);
        col       = mirror ? (20'(SPR_W - 1) - sx_full) : sx_full;
        addr_full = 13'(sy_full * 20'(SPR_W) + col);
        rom_address_next = in_box_s1_reg ? addr_full : 13'd0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box      <= 1'b0;
            rom_address <= '0;
        end else begin
            in_box      <= in_box_s1_reg;
            rom_address <= rom_address_next;
        end
    end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter action FSM with frame sequencing, sticky request latching and
// facing control, feeding a sprite address pipeline.
module fighter_anim_ctrl
    import fighter_anim_pkg::*;
#(
    parameter int BOX_W = DEF_BOX_W,
    parameter int BOX_H = DEF_BOX_H,
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        walk_req,
    input  logic        punch_req,
    input  logic        hit_req,
    input  logic        face_left,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [1:0]  anim_id,
    output logic [1:0]  frame_idx,
    output logic        mirror,
    output logic        busy,
    output logic        in_box,
    output logic [12:0] rom_address
);

    anim_t       state_reg, state_next;
    logic [1:0]  frame_reg, frame_next;
    logic [2:0]  tick_reg, tick_next;
    logic        mirror_reg, mirror_next;
    logic        punch_pend_reg, punch_pend_next;
    logic        hit_pend_reg, hit_pend_next;

    logic        punch_eff;
    logic        hit_eff;
    logic        attack;
    logic        last_tick;
    logic        last_frame;
    logic        finished;
    logic        restart;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            frame_reg      <= '0;
            tick_reg       <= '0;
            mirror_reg     <= 1'b0;
            punch_pend_reg <= 1'b0;
            hit_pend_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_reg      <= frame_next;
            tick_reg       <= tick_next;
            mirror_reg     <= mirror_next;
            punch_pend_reg <= punch_pend_next;
            hit_pend_reg   <= hit_pend_next;
        end
    end

    // A request arriving on the tick edge itself is seen by that tick
    assign punch_eff  = punch_pend_reg | punch_req;
    assign hit_eff    = hit_pend_reg | hit_req;
    assign attack     = (state_reg == PUNCH) || (state_reg == HITSTUN);
    assign last_tick  = (tick_reg == last_tick_of(state_reg));
    assign last_frame = (frame_reg == last_frame_of(state_reg));
    assign finished   = attack && last_tick && last_frame;

    always_comb begin
        state_next      = state_reg;
        frame_next      = frame_reg;
        tick_next       = tick_reg;
        mirror_next     = mirror_reg;
        punch_pend_next = punch_eff;
        hit_pend_next   = hit_eff;
        restart         = 1'b0;

        if (frame_tick) begin
            if (hit_eff) begin
                state_next      = HITSTUN;
                restart         = 1'b1;
                hit_pend_next   = 1'b0;
                punch_pend_next = 1'b0;
            end else if (attack && !finished) begin
                state_next = state_reg;
            end else if (punch_eff) begin
                state_next      = PUNCH;
                restart         = 1'b1;
                punch_pend_next = 1'b0;
            end else if (walk_req) begin
                state_next = WALK;
            end else begin
                state_next = IDLE;
            end

            if (restart || (state_next != state_reg)) begin
                frame_next = '0;
                tick_next  = '0;
            end else if (last_tick) begin
                tick_next  = '0;
                frame_next = last_frame ? 2'd0 : frame_reg + 2'd1;
            end else begin
                tick_next = tick_reg + 3'd1;
            end

            // Facing is frozen while attacking or stunned
            if ((state_next == IDLE) || (state_next == WALK)) begin
                mirror_next = face_left;
            end
        end
    end

    assign anim_id   = state_reg;
    assign frame_idx = frame_reg;
    assign mirror    = mirror_reg;
    assign busy      = attack;

    sprite_addr_gen #(
        .BOX_W(BOX_W),
        .BOX_H(BOX_H),
        .SPR_W(SPR_W),
        .SPR_H(SPR_H)
    ) u_addr (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .mirror      (mirror_reg),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .draw_x      (DrawX),
        .draw_y      (DrawY),
        .in_box      (in_box),
        .rom_address (rom_address)
    );

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed bench for fighter_anim_ctrl: sequencing, attacks, facing,
// address pipeline boundaries and asynchronous reset.
module tb_fighter_anim_ctrl;

    logic        vga_clk;
    logic        reset_n;
    logic        frame_tick;
    logic        walk_req;
    logic        punch_req;
    logic        hit_req;
    logic        face_left;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [1:0]  anim_id;
    logic [1:0]  frame_idx;
    logic        mirror;
    logic        busy;
    logic        in_box;
    logic [12:0] rom_address;

    int checks = 0;
    int errors = 0;

    fighter_anim_ctrl dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .walk_req    (walk_req),
        .punch_req   (punch_req),
        .hit_req     (hit_req),
        .face_left   (face_left),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .anim_id     (anim_id),
        .frame_idx   (frame_idx),
        .mirror      (mirror),
        .busy        (busy),
        .in_box      (in_box),
        .rom_address (rom_address)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_tick(input logic p, input logic h);
        @(negedge vga_clk);
        frame_tick = 1'b1;
        punch_req  = p;
        hit_req    = h;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        punch_req  = 1'b0;
        hit_req    = 1'b0;
    endtask

    task automatic pulse_req(input logic p, input logic h);
        @(negedge vga_clk);
        punch_req = p;
        hit_req   = h;
        @(negedge vga_clk);
        punch_req = 1'b0;
        hit_req   = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        checks++;
        if ({anim_id, frame_idx, mirror, busy, in_box, rom_address} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got anim=%0d frame=%0d mirror=%0d busy=%0d in_box=%0d addr=%0d, expected all 0",
                     anim_id, frame_idx, mirror, busy, in_box, rom_address);
        end
        @(negedge vga_clk);
        reset_n = 1'b1;
        $display("reset: anim=%0d frame=%0d", anim_id, frame_idx);
    endtask

    task automatic test_idle;
        for (int k = 1; k <= 32; k++) begin
            do_tick(1'b0, 1'b0);
            checks++;
            if (anim_id !== 2'd0 || frame_idx !== 2'((k / 8) % 4)) begin
                errors++;
                $display("FAIL idle_seq tick %0d: got anim=%0d frame=%0d expected anim=0 frame=%0d",
                         k, anim_id, frame_idx, (k / 8) % 4);
            end
            $display("idle tick %0d: anim=%0d frame=%0d", k, anim_id, frame_idx);
        end
    endtask

    task automatic test_punch;
        walk_req  = 1'b0;
        face_left = 1'b0;
        pulse_req(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            face_left = ~face_left;
            do_tick(1'b0, 1'b0);
            checks++;
            if (anim_id !== 2'd2 || frame_idx !== 2'(i / 4) || busy !== 1'b1 || mirror !== 1'b0) begin
                errors++;
                $display("FAIL punch_seq tick %0d: got anim=%0d frame=%0d busy=%0d mirror=%0d expected 2/%0d/1/0",
                         i, anim_id, frame_idx, busy, mirror, i / 4);
            end
            $display("punch tick %0d: anim=%0d frame=%0d busy=%0d mirror=%0d", i, anim_id, frame_idx, busy, mirror);
        end
        walk_req  = 1'b1;
        face_left = 1'b1;
        do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd1 || frame_idx !== 2'd0 || busy !== 1'b0 || mirror !== 1'b1) begin
            errors++;
            $display("FAIL punch_exit: got anim=%0d frame=%0d busy=%0d mirror=%0d expected 1/0/0/1",
                     anim_id, frame_idx, busy, mirror);
        end
        $display("punch exit: anim=%0d frame=%0d mirror=%0d", anim_id, frame_idx, mirror);
    endtask

    task automatic test_hit;
        walk_req  = 1'b0;
        face_left = 1'b0;
        do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd0 || mirror !== 1'b0) begin
            errors++;
            $display("FAIL walk_to_idle: got anim=%0d mirror=%0d expected 0/0", anim_id, mirror);
        end
        do_tick(1'b1, 1'b0);
        checks++;
        if (anim_id !== 2'd2 || frame_idx !== 2'd0) begin
            errors++;
            $display("FAIL punch_same_edge: got anim=%0d frame=%0d expected 2/0", anim_id, frame_idx);
        end
        repeat (4) do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd2 || frame_idx !== 2'd1) begin
            errors++;
            $display("FAIL punch_frame1: got anim=%0d frame=%0d expected 2/1", anim_id, frame_idx);
        end
        pulse_req(1'b1, 1'b1);
        do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd3 || frame_idx !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_entry: got anim=%0d frame=%0d busy=%0d expected 3/0/1", anim_id, frame_idx, busy);
        end
        for (int i = 1; i < 12; i++) begin
            do_tick(1'b0, 1'b0);
            checks++;
            if (anim_id !== 2'd3 || frame_idx !== 2'(i / 6)) begin
                errors++;
                $display("FAIL hitstun_seq tick %0d: got anim=%0d frame=%0d expected 3/%0d",
                         i, anim_id, frame_idx, i / 6);
            end
            $display("hitstun tick %0d: anim=%0d frame=%0d", i, anim_id, frame_idx);
        end
        do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd0 || frame_idx !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_exit_punch_discarded: got anim=%0d frame=%0d busy=%0d expected 0/0/0",
                     anim_id, frame_idx, busy);
        end
        $display("hitstun exit: anim=%0d frame=%0d", anim_id, frame_idx);
    endtask

    task automatic addr_vec(input logic [9:0] x, input logic [9:0] y,
                            input logic exp_in, input logic [12:0] exp_addr);
        @(negedge vga_clk);
        DrawX = x;
        DrawY = y;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        checks++;
        if (in_box !== exp_in || rom_address !== exp_addr) begin
            errors++;
            $display("FAIL addr (%0d,%0d) pos (%0d,%0d) m=%0d: got in_box=%0d addr=%0d expected %0d/%0d",
                     x, y, pos_x, pos_y, mirror, in_box, rom_address, exp_in, exp_addr);
        end
        $display("addr (%0d,%0d) m=%0d: in_box=%0d addr=%0d", x, y, mirror, in_box, rom_address);
    endtask

    task automatic test_addr;
        pos_x = 10'd100;
        pos_y = 10'd200;
        addr_vec(10'd100, 10'd200, 1'b1, 13'd0);
        addr_vec(10'd179, 10'd359, 1'b1, 13'd5399);
        addr_vec(10'd180, 10'd359, 1'b0, 13'd0);
        addr_vec(10'd99,  10'd200, 1'b0, 13'd0);
        addr_vec(10'd100, 10'd199, 1'b0, 13'd0);
        addr_vec(10'd100, 10'd360, 1'b0, 13'd0);
        addr_vec(10'd140, 10'd280, 1'b1, 13'd2730);

        // Latency: one edge after moving into the box the output is still old
        @(negedge vga_clk);
        DrawX = 10'd99;
        repeat (3) @(negedge vga_clk);
        DrawX = 10'd100;
        @(posedge vga_clk);
        #1;
        checks++;
        if (in_box !== 1'b0) begin
            errors++;
            $display("FAIL addr_latency_stage1: got in_box=%0d expected 0", in_box);
        end
        @(posedge vga_clk);
        #1;
        checks++;
        if (in_box !== 1'b1) begin
            errors++;
            $display("FAIL addr_latency_stage2: got in_box=%0d expected 1", in_box);
        end

        face_left = 1'b1;
        do_tick(1'b0, 1'b0);
        addr_vec(10'd100, 10'd200, 1'b1, 13'd59);
        addr_vec(10'd179, 10'd359, 1'b1, 13'd5340);
        addr_vec(10'd140, 10'd280, 1'b1, 13'd2729);

        pos_x = 10'd5;
        pos_y = 10'd0;
        addr_vec(10'd0,    10'd10, 1'b0, 13'd0);
        pos_x = 10'd0;
        addr_vec(10'd1023, 10'd10, 1'b0, 13'd0);
        addr_vec(10'd0,    10'd0,  1'b1, 13'd59);
    endtask

    task automatic test_reset_mid_walk;
        pos_x     = 10'd100;
        pos_y     = 10'd200;
        DrawX     = 10'd100;
        DrawY     = 10'd200;
        face_left = 1'b1;
        walk_req  = 1'b1;
        do_tick(1'b0, 1'b0);
        repeat (12) do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd1 || frame_idx !== 2'd2 || in_box !== 1'b1 || mirror !== 1'b1) begin
            errors++;
            $display("FAIL walk_frame2: got anim=%0d frame=%0d in_box=%0d mirror=%0d expected 1/2/1/1",
                     anim_id, frame_idx, in_box, mirror);
        end
        pulse_req(1'b1, 1'b0);
        @(negedge vga_clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({anim_id, frame_idx, mirror, busy, in_box, rom_address} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got anim=%0d frame=%0d mirror=%0d busy=%0d in_box=%0d addr=%0d expected all 0",
                     anim_id, frame_idx, mirror, busy, in_box, rom_address);
        end
        @(negedge vga_clk);
        reset_n  = 1'b1;
        walk_req = 1'b0;
        do_tick(1'b0, 1'b0);
        checks++;
        if (anim_id !== 2'd0 || frame_idx !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tick: got anim=%0d frame=%0d busy=%0d expected 0/0/0",
                     anim_id, frame_idx, busy);
        end
        $display("post reset tick: anim=%0d frame=%0d", anim_id, frame_idx);
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        walk_req   = 1'b0;
        punch_req  = 1'b0;
        hit_req    = 1'b0;
        face_left  = 1'b0;
        pos_x      = 10'd100;
        pos_y      = 10'd200;
        DrawX      = 10'd0;
        DrawY      = 10'd0;
        test_reset;
        test_idle;
        test_punch;
        test_hit;
        test_addr;
        test_reset_mid_walk;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
